jtframe_sdram_arb: RTL and testbench

JTFRAME_SDRAM_ARB -- requirements
Module: jtframe_sdram_arb

---
 rtl/jtframe_sdram_arb_pkg.sv | 15 +
 rtl/jtframe_rr_pick.sv | 25 ++
 rtl/jtframe_sdram_arb.sv | 171 +++++++++++++++++
 tb/tb_jtframe_sdram_arb.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_sdram_arb_pkg.sv
// Shared types and default sizes for the SDRAM read arbiter.
// The arbiter FSM walks IDLE -> WAIT_ACK -> WAIT_RDY for each granted slot.
package jtframe_sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        WAIT_RDY = 2'd2
    } arb_state_e;

    localparam int ARB_AW   = 22;
    localparam int ARB_DW   = 32;
    localparam int ARB_TOUT = 255;

endpackage

// File: rtl/jtframe_rr_pick.sv
// Combinational round-robin picker: the first requesting slot found
// when scanning from last+1 upwards, wrapping at SLOTS-1.
module jtframe_rr_pick
    import jtframe_sdram_arb_pkg::*;
#(
    parameter int SLOTS = 4,
    parameter int IW    = $clog2(SLOTS)
)(
    input  logic [SLOTS-1:0] req,
    input  logic [IW-1:0]    last,
    output logic [IW-1:0]    grant,
    output logic             valid
);

    // Scan farthest-first so the nearest requester after last overrides the rest
    always_comb begin
        grant = last;
        valid = 1'b0;
        for (int k = SLOTS; k >= 1; k--) begin
            grant = req[(int'(last) + k) % SLOTS] ? IW'((int'(last) + k) % SLOTS) : grant;
            valid = req[(int'(last) + k) % SLOTS] | valid;
        end
    end

endmodule

// File: rtl/jtframe_sdram_arb.sv
// Round-robin arbiter sharing one SDRAM read port among SLOTS requesters,
// with a bounded wait for read data and a sticky timeout flag.
module jtframe_sdram_arb
    import jtframe_sdram_arb_pkg::*;
#(
    parameter int SLOTS = 4,
    parameter int AW    = ARB_AW,
    parameter int DW    = ARB_DW,
    parameter int TOUT  = ARB_TOUT
)(
    input  logic                clk_sys,
    input  logic                RESET,
    input  logic                loop_rst,
    input  logic                downloading,
    input  logic [SLOTS-1:0]    slot_req,
    input  logic [SLOTS*AW-1:0] slot_addr,
    output logic [SLOTS-1:0]    slot_ack,
    output logic [SLOTS-1:0]    slot_rdy,
    output logic [DW-1:0]       slot_dout,
    output logic                sdram_req,
    output logic [AW-1:0]       sdram_addr,
    input  logic                sdram_ack,
    input  logic [DW-1:0]       data_read,
    input  logic                data_rdy,
    output logic                refresh_en,
    output logic                timeout_err
);

    localparam int              IW        = $clog2(SLOTS);
    localparam logic [7:0]      TOUT_LAST = 8'(TOUT - 1);
    localparam logic [SLOTS-1:0] ONE_HOT0 = {{(SLOTS-1){1'b0}}, 1'b1};

    arb_state_e       state_r, state_s;
    logic [IW-1:0]    gnt_r, gnt_s;
    logic [IW-1:0]    last_r, last_s;
    logic [7:0]       cnt_r, cnt_s;
    logic             req_r, req_s;
    logic [AW-1:0]    addr_r, addr_s;
    logic [SLOTS-1:0] ack_r, ack_s;
    logic [SLOTS-1:0] rdy_r, rdy_s;
    logic [DW-1:0]    dout_r, dout_s;
    logic             terr_r, terr_s;

    logic [IW-1:0]    pick_s;
    logic             pick_valid_s;
    logic             grant_s;
    logic [AW-1:0]    pick_addr_s;
    logic [SLOTS-1:0] gmask_s;

    jtframe_rr_pick #(
        .SLOTS (SLOTS),
        .IW    (IW)
    ) u_pick (
        .req   (slot_req),
        .last  (last_r),
        .grant (pick_s),
        .valid (pick_valid_s)
    );

    assign pick_addr_s = slot_addr[pick_s*AW +: AW];
    assign gmask_s     = ONE_HOT0 << gnt_r;
    assign grant_s     = (state_r == IDLE) && !downloading && pick_valid_s && !loop_rst;

    assign refresh_en  = (state_r == IDLE) && !grant_s;
    assign slot_ack    = ack_r;
    assign slot_rdy    = rdy_r;
    assign slot_dout   = dout_r;
    assign sdram_req   = req_r;
    assign sdram_addr  = addr_r;
    assign timeout_err = terr_r;

    // Next-state and next-output computation for the transaction FSM
    always_comb begin
        state_s = state_r;
        gnt_s   = gnt_r;
        last_s  = last_r;
        cnt_s   = cnt_r;
        req_s   = req_r;
        addr_s  = addr_r;
        ack_s   = {SLOTS{1'b0}};
        rdy_s   = {SLOTS{1'b0}};
        dout_s  = dout_r;
        terr_s  = terr_r;
        if (loop_rst) begin
            // Abort silently; the timeout flag survives on purpose
            state_s = IDLE;
            req_s   = 1'b0;
            cnt_s   = 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        gnt_s   = pick_s;
                        addr_s  = pick_addr_s;
                        req_s   = 1'b1;
                        state_s = WAIT_ACK;
                    end else begin
                        req_s   = 1'b0;
                    end
                end
                WAIT_ACK: begin
                    if (sdram_ack) begin
                        req_s = 1'b0;
                        ack_s = gmask_s;
                        cnt_s = 8'd0;
                        if (data_rdy) begin
                            rdy_s   = gmask_s;
                            dout_s  = data_read;
                            last_s  = gnt_r;
                            state_s = IDLE;
                        end else begin
                            state_s = WAIT_RDY;
                        end
                    end else begin
                        req_s = 1'b1;
                    end
                end
                WAIT_RDY: begin
                    if (data_rdy) begin
                        rdy_s   = gmask_s;
                        dout_s  = data_read;
                        last_s  = gnt_r;
                        cnt_s   = 8'd0;
                        state_s = IDLE;
                    end else if (cnt_r == TOUT_LAST) begin
                        // TOUT cycles spent here without data: give up on this slot
                        terr_s  = 1'b1;
                        last_s  = gnt_r;
                        cnt_s   = 8'd0;
                        state_s = IDLE;
                    end else begin
                        cnt_s   = cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_s = IDLE;
                    req_s   = 1'b0;
                    cnt_s   = 8'd0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            state_r <= IDLE;
            gnt_r   <= {IW{1'b0}};
            last_r  <= IW'(SLOTS - 1);
            cnt_r   <= 8'd0;
            req_r   <= 1'b0;
            addr_r  <= {AW{1'b0}};
            ack_r   <= {SLOTS{1'b0}};
            rdy_r   <= {SLOTS{1'b0}};
            dout_r  <= {DW{1'b0}};
            terr_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            gnt_r   <= gnt_s;
            last_r  <= last_s;
            cnt_r   <= cnt_s;
            req_r   <= req_s;
            addr_r  <= addr_s;
            ack_r   <= ack_s;
            rdy_r   <= rdy_s;
            dout_r  <= dout_s;
            terr_r  <= terr_s;
        end
    end

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// Self-checking bench for jtframe_sdram_arb: a transaction-level model tracks
// the round-robin pointer and the last delivered word; the bench plays SDRAM.
module tb_jtframe_sdram_arb;

    localparam int SLOTS = 4;
    localparam int AW    = 22;
    localparam int DW    = 32;

    logic                clk_sys;
    logic                RESET;
    logic                loop_rst;
    logic                downloading;
    logic [SLOTS-1:0]    slot_req;
    logic [SLOTS*AW-1:0] slot_addr;
    logic [SLOTS-1:0]    slot_ack;
    logic [SLOTS-1:0]    slot_rdy;
    logic [DW-1:0]       slot_dout;
    logic                sdram_req;
    logic [AW-1:0]       sdram_addr;
    logic                sdram_ack;
    logic [DW-1:0]       data_read;
    logic                data_rdy;
    logic                refresh_en;
    logic                timeout_err;

    int checks = 0;
    int passes = 0;
    int exp_last;
    logic [DW-1:0] exp_dout;
    logic [AW-1:0] addr_tab [SLOTS];

    jtframe_sdram_arb #(.SLOTS(SLOTS), .AW(AW), .DW(DW), .TOUT(255)) dut (
        .clk_sys     (clk_sys),
        .RESET       (RESET),
        .loop_rst    (loop_rst),
        .downloading (downloading),
        .slot_req    (slot_req),
        .slot_addr   (slot_addr),
        .slot_ack    (slot_ack),
        .slot_rdy    (slot_rdy),
        .slot_dout   (slot_dout),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_ack   (sdram_ack),
        .data_read   (data_read),
        .data_rdy    (data_rdy),
        .refresh_en  (refresh_en),
        .timeout_err (timeout_err)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Round-robin rule: first requesting slot after last, wrapping around
    function automatic int rr_next(input int last, input logic [SLOTS-1:0] req);
        int r = -1;
        for (int k = 1; k <= SLOTS; k++) begin
            int s = (last + k) % SLOTS;
            if (r < 0 && req[s]) r = s;
        end
        return r;
    endfunction

    task automatic step();
        @(negedge clk_sys);
    endtask

    task automatic pack_addrs();
        for (int i = 0; i < SLOTS; i++) slot_addr[i*AW +: AW] = addr_tab[i];
    endtask

    task automatic set_addrs();
        for (int i = 0; i < SLOTS; i++) addr_tab[i] = AW'($urandom);
        pack_addrs();
    endtask

    // One complete read for the slot the model says wins; rdy_dly==0 means ack and rdy together
    task automatic do_txn(input logic [SLOTS-1:0] mask, input int ack_dly, input int rdy_dly,
                          input logic [DW-1:0] data, input bit drop, input bit dl_mid,
                          output int got_g);
        int g;
        logic [SLOTS-1:0] gm;
        logic [AW-1:0] exp_addr;
        g = rr_next(exp_last, mask);
        gm = 4'b0001 << g;
        exp_addr = addr_tab[g];
        slot_req = mask;
        step();
        checks++;
        if (sdram_req !== 1'b1 || sdram_addr !== exp_addr) begin
            $display("FAIL grant_req: sdram_req=%b addr=%h, expected 1 %h (slot %0d)", sdram_req, sdram_addr, exp_addr, g);
        end else passes++;
        checks++;
        if (slot_ack !== 4'b0000 || slot_rdy !== 4'b0000 || refresh_en !== 1'b0) begin
            $display("FAIL grant_quiet: ack=%b rdy=%b refresh_en=%b, expected 0000 0000 0", slot_ack, slot_rdy, refresh_en);
        end else passes++;
        if (drop) slot_req = 4'b0000;
        set_addrs();
        for (int i = 0; i < ack_dly; i++) begin
            step();
            checks++;
            if (sdram_req !== 1'b1 || sdram_addr !== exp_addr || slot_ack !== 4'b0000) begin
                $display("FAIL hold_ack: sdram_req=%b addr=%h ack=%b, expected 1 %h 0000", sdram_req, sdram_addr, slot_ack, exp_addr);
            end else passes++;
        end
        sdram_ack = 1'b1;
        data_rdy  = (rdy_dly == 0);
        data_read = (rdy_dly == 0) ? data : DW'($urandom);
        step();
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        data_read = DW'($urandom);
        got_g = -1;
        if ($countones(slot_ack) == 1)
            for (int i = 0; i < SLOTS; i++) if (slot_ack[i]) got_g = i;
        checks++;
        if (slot_ack !== gm || sdram_req !== 1'b0) begin
            $display("FAIL ack_pulse: ack=%b sdram_req=%b, expected %b 0", slot_ack, sdram_req, gm);
        end else passes++;
        if (rdy_dly == 0) begin
            checks++;
            if (slot_rdy !== gm || slot_dout !== data) begin
                $display("FAIL simul_rdy: rdy=%b dout=%h, expected %b %h", slot_rdy, slot_dout, gm, data);
            end else passes++;
        end else begin
            checks++;
            if (slot_rdy !== 4'b0000 || slot_dout !== exp_dout) begin
                $display("FAIL after_ack: rdy=%b dout=%h, expected 0000 %h", slot_rdy, slot_dout, exp_dout);
            end else passes++;
            if (dl_mid) downloading = 1'b1;
            for (int i = 1; i < rdy_dly; i++) begin
                step();
                checks++;
                if (slot_rdy !== 4'b0000 || slot_ack !== 4'b0000 || slot_dout !== exp_dout) begin
                    $display("FAIL wait_rdy: ack=%b rdy=%b dout=%h, expected 0000 0000 %h", slot_ack, slot_rdy, slot_dout, exp_dout);
                end else passes++;
            end
            data_read = data;
            data_rdy  = 1'b1;
            step();
            data_rdy  = 1'b0;
            data_read = DW'($urandom);
            checks++;
            if (slot_rdy !== gm || slot_ack !== 4'b0000 || slot_dout !== data) begin
                $display("FAIL rdy_pulse: rdy=%b ack=%b dout=%h, expected %b 0000 %h", slot_rdy, slot_ack, slot_dout, gm, data);
            end else passes++;
        end
        exp_last = g;
        exp_dout = data;
    endtask

    task automatic go_idle();
        slot_req = 4'b0000;
        step();
    endtask

    task automatic test_reset();
        RESET = 1'b1; loop_rst = 1'b0; downloading = 1'b0; slot_req = 4'b0000;
        sdram_ack = 1'b0; data_rdy = 1'b0; data_read = 32'h0;
        set_addrs();
        step(); step();
        checks++;
        if (sdram_req !== 1'b0 || sdram_addr !== 22'h0 || slot_ack !== 4'b0000 || slot_rdy !== 4'b0000) begin
            $display("FAIL reset_ctrl: req=%b addr=%h ack=%b rdy=%b, expected 0 0 0000 0000", sdram_req, sdram_addr, slot_ack, slot_rdy);
        end else passes++;
        checks++;
        if (slot_dout !== 32'h0 || timeout_err !== 1'b0 || refresh_en !== 1'b1) begin
            $display("FAIL reset_data: dout=%h timeout_err=%b refresh_en=%b, expected 0 0 1", slot_dout, timeout_err, refresh_en);
        end else passes++;
        RESET = 1'b0;
        step();
        checks++;
        if (sdram_req !== 1'b0 || refresh_en !== 1'b1) begin
            $display("FAIL reset_idle: req=%b refresh_en=%b, expected 0 1", sdram_req, refresh_en);
        end else passes++;
        exp_last = SLOTS - 1;
        exp_dout = 32'h0;
    endtask

    task automatic test_round_robin();
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int g;
        for (int i = 0; i < 5; i++) begin
            do_txn(4'b1111, 2, 3, DW'($urandom), 1'b0, 1'b0, g);
            checks++;
            if (g !== exp_order[i]) begin
                $display("FAIL rr_order[%0d]: granted %0d, expected %0d", i, g, exp_order[i]);
            end else passes++;
        end
        go_idle();
    endtask

    task automatic test_addr_data();
        int g;
        set_addrs();
        addr_tab[2] = 22'h12345;
        pack_addrs();
        do_txn(4'b0100, 1, 2, 32'hDEADBEEF, 1'b1, 1'b0, g);
        checks++;
        if (g !== 2 || slot_dout !== 32'hDEADBEEF) begin
            $display("FAIL addr_data: slot %0d dout=%h, expected 2 deadbeef", g, slot_dout);
        end else passes++;
        go_idle();
    endtask

    task automatic test_simultaneous();
        int g;
        do_txn(4'b1010, 1, 0, DW'($urandom), 1'b1, 1'b0, g);
        checks++;
        if (refresh_en !== 1'b1 || sdram_req !== 1'b0) begin
            $display("FAIL simul_idle: refresh_en=%b req=%b, expected 1 0", refresh_en, sdram_req);
        end else passes++;
        go_idle();
    endtask

    task automatic test_back_to_back();
        int g;
        for (int n = 0; n < 20; n++) begin
            do_txn(4'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 4),
                   DW'($urandom), 1'($urandom_range(0, 1)), 1'b0, g);
        end
        go_idle();
    endtask

    task automatic test_download();
        int g;
        do_txn(4'b0011, 1, 3, DW'($urandom), 1'b0, 1'b1, g);
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (sdram_req !== 1'b0 || refresh_en !== 1'b1 || slot_ack !== 4'b0000) begin
                $display("FAIL dl_block: req=%b refresh_en=%b ack=%b, expected 0 1 0000", sdram_req, refresh_en, slot_ack);
            end else passes++;
        end
        downloading = 1'b0;
        do_txn(4'b0011, 1, 2, DW'($urandom), 1'b0, 1'b0, g);
        go_idle();
    endtask

    task automatic test_timeout();
        int g, n;
        bit saw_rdy;
        logic [SLOTS-1:0] gm;
        g = rr_next(exp_last, 4'b0011);
        gm = 4'b0001 << g;
        slot_req = 4'b0011;
        step();
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
        checks++;
        if (slot_ack !== gm) begin
            $display("FAIL to_ack: ack=%b, expected %b", slot_ack, gm);
        end else passes++;
        n = 0;
        saw_rdy = 1'b0;
        while (timeout_err !== 1'b1 && n < 300) begin
            step();
            n++;
            if (slot_rdy !== 4'b0000) saw_rdy = 1'b1;
        end
        checks++;
        if (n !== 255) begin
            $display("FAIL to_cycles: timeout after %0d cycles, expected 255", n);
        end else passes++;
        checks++;
        if (saw_rdy !== 1'b0 || slot_dout !== exp_dout) begin
            $display("FAIL to_no_rdy: saw_rdy=%b dout=%h, expected 0 %h", saw_rdy, slot_dout, exp_dout);
        end else passes++;
        exp_last = g;
        do_txn(4'b0011, 1, 2, DW'($urandom), 1'b0, 1'b0, n);
        checks++;
        if (n !== rr_next(g, 4'b0011) || timeout_err !== 1'b1) begin
            $display("FAIL to_next: slot %0d timeout_err=%b, expected %0d 1", n, timeout_err, rr_next(g, 4'b0011));
        end else passes++;
        go_idle();
    endtask

    task automatic test_loop_rst();
        slot_req = 4'b0001;
        step();
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
        slot_req  = 4'b0000;
        loop_rst  = 1'b1;
        step();
        loop_rst  = 1'b0;
        checks++;
        if (sdram_req !== 1'b0 || slot_ack !== 4'b0000 || slot_rdy !== 4'b0000 || refresh_en !== 1'b1 || timeout_err !== 1'b1) begin
            $display("FAIL loop_rst: req=%b ack=%b rdy=%b refresh_en=%b terr=%b, expected 0 0000 0000 1 1",
                     sdram_req, slot_ack, slot_rdy, refresh_en, timeout_err);
        end else passes++;
        data_read = DW'($urandom);
        data_rdy  = 1'b1;
        step();
        data_rdy  = 1'b0;
        step();
        checks++;
        if (slot_rdy !== 4'b0000 || slot_dout !== exp_dout) begin
            $display("FAIL loop_rst_quiet: rdy=%b dout=%h, expected 0000 %h", slot_rdy, slot_dout, exp_dout);
        end else passes++;
    endtask

    task automatic test_reset_mid();
        int g;
        slot_req = 4'b1111;
        step();
        checks++;
        if (sdram_req !== 1'b1) begin
            $display("FAIL rm_pre: req=%b, expected 1", sdram_req);
        end else passes++;
        RESET = 1'b1;
        #1;
        checks++;
        if (sdram_req !== 1'b0 || timeout_err !== 1'b0 || slot_dout !== 32'h0) begin
            $display("FAIL rm_async: req=%b terr=%b dout=%h, expected 0 0 0", sdram_req, timeout_err, slot_dout);
        end else passes++;
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
        RESET = 1'b0;
        exp_last = SLOTS - 1;
        exp_dout = 32'h0;
        do_txn(4'b1111, 1, 1, DW'($urandom), 1'b1, 1'b0, g);
        checks++;
        if (g !== 0) begin
            $display("FAIL rm_first: granted %0d, expected 0", g);
        end else passes++;
        go_idle();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_addr_data();
        test_simultaneous();
        test_back_to_back();
        test_download();
        test_timeout();
        test_loop_rst();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
